// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with operand select and writeback forwarding.
// Latency: an accepted decode instruction appears on the EX outputs one cycle later.
// Backpressure: ex_stall holds EX; without ID_EX_BYPASS_EN, id_stall holds decode on RAW hazards.
// Optional feature macro: ID_EX_BYPASS_EN (writeback forwarding instead of hazard stalls).
module id_ex_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic        id_use_pc,
  input  logic        id_use_imm,
  input  logic [3:0]  id_alu_sel,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rd_we,
  input  logic        id_is_load,
  input  logic [4:0]  wb_rd_addr,
  input  logic        wb_rd_we,
  input  logic [31:0] wb_rd_data,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic        ex_rd_we,
  output logic        ex_is_load,
  output logic [4:0]  ex_rd_addr,
  output logic [31:0] ex_pc,
  output logic [3:0]  alu_sel,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [31:0] ex_store_data
);

  localparam logic [3:0] ALU_SEL_ADD = 4'h0;

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
  logic        rs1_used_q, rs1_used_d, rs2_used_q, rs2_used_d;
  logic [31:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
  logic [31:0] imm_q, imm_d;
  logic        use_pc_q, use_pc_d, use_imm_q, use_imm_d;
  logic [3:0]  alu_sel_q, alu_sel_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        rd_we_q, rd_we_d, is_load_q, is_load_d;

  // Writeback hits against the indices held in EX; x0 never matches.
  logic ex_hit1, ex_hit2;
  assign ex_hit1 = wb_rd_we && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs1_addr_q);
  assign ex_hit2 = wb_rd_we && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs2_addr_q);

  logic [31:0] cap1, cap2, eff1, eff2;

  // The used flags travel with the instruction but no EX logic consumes them.
  logic unused_q_flags;
  assign unused_q_flags = rs1_used_q ^ rs2_used_q;

`ifdef ID_EX_BYPASS_EN
  logic id_hit1, id_hit2;
  assign id_hit1 = wb_rd_we && (wb_rd_addr != 5'd0) && (wb_rd_addr == id_rs1_addr);
  assign id_hit2 = wb_rd_we && (wb_rd_addr != 5'd0) && (wb_rd_addr == id_rs2_addr);
  assign cap1    = id_hit1 ? wb_rd_data : id_rs1_data;
  assign cap2    = id_hit2 ? wb_rd_data : id_rs2_data;
  assign eff1    = ex_hit1 ? wb_rd_data : rs1_val_q;
  assign eff2    = ex_hit2 ? wb_rd_data : rs2_val_q;
  assign id_stall = 1'b0;
  // Forwarding makes the decode used flags irrelevant.
  logic unused_id_flags;
  assign unused_id_flags = id_rs1_used ^ id_rs2_used;
`else
  logic haz1, haz2;
  assign cap1 = id_rs1_data;
  assign cap2 = id_rs2_data;
  assign eff1 = rs1_val_q;
  assign eff2 = rs2_val_q;
  // Without forwarding, decode waits until no in-flight writer of its sources remains.
  assign haz1 = id_rs1_used && (id_rs1_addr != 5'd0) &&
                ((valid_q && rd_we_q && (id_rs1_addr == rd_addr_q)) ||
                 (wb_rd_we && (id_rs1_addr == wb_rd_addr)));
  assign haz2 = id_rs2_used && (id_rs2_addr != 5'd0) &&
                ((valid_q && rd_we_q && (id_rs2_addr == rd_addr_q)) ||
                 (wb_rd_we && (id_rs2_addr == wb_rd_addr)));
  assign id_stall = id_valid && (haz1 || haz2);
`endif

  // Next-state selection: flush, then stall (with held-operand refresh), then load or bubble.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rs1_used_d = rs1_used_q;
    rs2_used_d = rs2_used_q;
    rs1_val_d  = rs1_val_q;
    rs2_val_d  = rs2_val_q;
    imm_d      = imm_q;
    use_pc_d   = use_pc_q;
    use_imm_d  = use_imm_q;
    alu_sel_d  = alu_sel_q;
    rd_addr_d  = rd_addr_q;
    rd_we_d    = rd_we_q;
    is_load_d  = is_load_q;
    if (flush) begin
      valid_d   = 1'b0;
      rd_we_d   = 1'b0;
      is_load_d = 1'b0;
    end else if (ex_stall) begin
      if (ex_hit1) rs1_val_d = wb_rd_data;
      if (ex_hit2) rs2_val_d = wb_rd_data;
    end else if (id_valid && !id_stall) begin
      valid_d    = 1'b1;
      pc_d       = id_pc;
      rs1_addr_d = id_rs1_addr;
      rs2_addr_d = id_rs2_addr;
      rs1_used_d = id_rs1_used;
      rs2_used_d = id_rs2_used;
      rs1_val_d  = cap1;
      rs2_val_d  = cap2;
      imm_d      = id_imm;
      use_pc_d   = id_use_pc;
      use_imm_d  = id_use_imm;
      alu_sel_d  = id_alu_sel;
      rd_addr_d  = id_rd_addr;
      rd_we_d    = id_rd_we;
      is_load_d  = id_is_load;
    end else begin
      valid_d   = 1'b0;
      rd_we_d   = 1'b0;
      is_load_d = 1'b0;
    end
  end

  // EX register set with synchronous reset overriding every other action.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      rs1_addr_q <= 5'd0;
      rs2_addr_q <= 5'd0;
      rs1_used_q <= 1'b0;
      rs2_used_q <= 1'b0;
      rs1_val_q  <= 32'd0;
      rs2_val_q  <= 32'd0;
      imm_q      <= 32'd0;
      use_pc_q   <= 1'b0;
      use_imm_q  <= 1'b0;
      alu_sel_q  <= ALU_SEL_ADD;
      rd_addr_q  <= 5'd0;
      rd_we_q    <= 1'b0;
      is_load_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rs1_used_q <= rs1_used_d;
      rs2_used_q <= rs2_used_d;
      rs1_val_q  <= rs1_val_d;
      rs2_val_q  <= rs2_val_d;
      imm_q      <= imm_d;
      use_pc_q   <= use_pc_d;
      use_imm_q  <= use_imm_d;
      alu_sel_q  <= alu_sel_d;
      rd_addr_q  <= rd_addr_d;
      rd_we_q    <= rd_we_d;
      is_load_q  <= is_load_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_rd_we      = rd_we_q;
  assign ex_is_load    = is_load_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_pc         = pc_q;
  assign alu_sel       = alu_sel_q;
  assign alu_in1       = use_pc_q ? pc_q : eff1;
  assign alu_in2       = use_imm_q ? imm_q : eff2;
  assign ex_store_data = eff2;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, reset value of ex_pc.
REQ-002 SHALL have ports, one per line:
 clk  in  1  system clock, all state on rising edge
 rst  in  1  reset, synchronous and active-high
 id_valid  in  1  decode stage presents a valid instruction
 id_pc  in  32  instruction PC
 id_rs1_addr, id_rs2_addr  in  5 each  source register indices
 id_rs1_used, id_rs2_used  in  1 each  instruction reads rs1/rs2
 id_rs1_data, id_rs2_data  in  32 each  register-file read data
 id_imm  in  32  sign-extended immediate
 id_use_pc  in  1  operand 1 = PC instead of rs1
 id_use_imm  in  1  operand 2 = immediate instead of rs2
 id_alu_sel  in  4  ALU operation code
 id_rd_addr  in  5  destination index; id_rd_we  in  1  writes rd; id_is_load  in  1  load
 wb_rd_addr  in  5; wb_rd_we  in  1; wb_rd_data  in  32  writeback-stage result
 ex_stall  in  1  downstream hold
 flush  in  1  kill instruction held in EX (branch taken / trap)
 id_stall  out  1  decode must hold its instruction
 ex_valid, ex_rd_we, ex_is_load  out  1 each; ex_rd_addr  out  5; ex_pc  out  32
 alu_sel  out  4; alu_in1, alu_in2  out  32  ALU operands
 ex_store_data  out  32  forwarded rs2 value for stores

Function
REQ-003 SHALL hold one instruction in the EX register set: pc, rs1/rs2 indices, used flags, rs1/rs2 values, imm, use_pc, use_imm, alu_sel, rd_addr, rd_we, is_load, valid.
REQ-004 Priority each clock edge: rst > flush > ex_stall > load/bubble.
REQ-005 flush=1 SHALL clear ex_valid, ex_rd_we and ex_is_load next cycle, even with ex_stall=1; other fields don't care.
REQ-006 ex_stall=1 (no flush) SHALL hold all fields; held rs1/rs2 values SHALL be replaced by wb_rd_data when wb_rd_we=1, wb_rd_addr nonzero and equal to the held index.
REQ-007 Else, id_valid=1 and id_stall=0 SHALL load the decode fields, one-cycle latency, ex_valid=1.
REQ-008 Else (id_valid=0 or id_stall=1) SHALL load a bubble: ex_valid=0, ex_rd_we=0, ex_is_load=0.
REQ-009 On load, captured rs1/rs2 values SHALL be wb_rd_data when wb_rd_we=1, wb_rd_addr nonzero and equal to the id index, else id_rs*_data.
REQ-010 Effective rs value = wb_rd_data when wb_rd_we=1, wb_rd_addr nonzero and equal to the EX index, else the held value (combinational).
REQ-011 alu_in1 = ex_pc if use_pc else effective rs1; alu_in2 = imm if use_imm else effective rs2; ex_store_data = effective rs2.
REQ-012 Register index 0 SHALL never match for forwarding or hazard.
REQ-013 ex_valid=0 SHALL guarantee ex_rd_we=0 and ex_is_load=0.

Reset
REQ-014 rst=1 at an edge SHALL set ex_valid, ex_rd_we, ex_is_load=0, ex_rd_addr=0, ex_pc=RESET_PC, alu_sel=ALU_SEL_ADD, held rs values, imm, use flags=0, overriding flush/stall mid-operation; id_stall SHALL be 0 while ex_valid=0 and wb_rd_we=0.

Configuration
REQ-015 Macro ID_EX_BYPASS_EN defined: REQ-009 and REQ-010 forwarding active; id_stall tied 0.
REQ-016 ID_EX_BYPASS_EN undefined: no forwarding (captured = id_rs*_data, effective = held value); id_stall=1 when id_valid=1 and a used nonzero id source index equals ex_rd_addr with ex_valid=1 and ex_rd_we=1, or equals wb_rd_addr with wb_rd_we=1; otherwise 0.

Verification
REQ-017 Reset then idle -> ex_valid=0, ex_pc=RESET_PC, alu_sel=ALU_SEL_ADD, id_stall=0.
REQ-018 ADDI x1 (rs1=x2=5, imm=7, use_imm) -> next cycle alu_in1=5, alu_in2=7, ex_rd_addr=1, ex_valid=1.
REQ-019 BYPASS_EN: EX writes x3, next ID reads x3 while WB presents x3=0x1234 -> alu_in1=0x1234, id_stall=0; undefined: id_stall=1 two cycles, then alu_in1 from register file.
REQ-020 ex_stall=1 three cycles with wb writing held rs2=x4=0xAA -> fields held, ex_store_data=0xAA after release.
REQ-021 flush=1 with ex_stall=1 -> ex_valid=0 next cycle; wb_rd_addr=0, wb_rd_we=1 -> no forwarding.
